// File: rtl/gb_apu_i2s_out.sv
// gb_apu_i2s_out: FIFO-buffered 24-bit stereo I2S serialiser for the GBC audio mixer.
// An empty FIFO at frame start mutes that frame and raises a one-cycle Underrun pulse.
module gb_apu_i2s_out #(
  parameter int FifoDepth      = 16,
  parameter int BclkHalfPeriod = 8
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic                         Enable,
  input  logic                         SampleValid,
  input  logic [23:0]                  SampleLeft,
  input  logic [23:0]                  SampleRight,
  output logic                         SampleReady,
  output logic [$clog2(FifoDepth):0]   Level,
  output logic                         Underrun,
  output logic                         BCLK,
  output logic                         LRCLK,
  output logic                         SDATA
);

  localparam int AW = $clog2(FifoDepth);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(BclkHalfPeriod);
  localparam logic [LW-1:0] LevelFull = LW'(FifoDepth);
  localparam logic [DW-1:0] DivLast   = DW'(BclkHalfPeriod - 1);
  localparam logic [0:0]    StIdle    = 1'b0;
  localparam logic [0:0]    StRun     = 1'b1;

  logic [47:0]   mem_q [FifoDepth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [0:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic [23:0]   left_q, left_d, right_q, right_d;
  logic          bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic          underrun_q, underrun_d;
  logic          push_s, pop_s, fifo_empty_s, frame_start_s;
  logic [5:0]    bit_nxt_s;

  assign push_s       = SampleValid && (level_q != LevelFull);
  assign fifo_empty_s = (level_q == {LW{1'b0}});
  assign pop_s        = frame_start_s && !fifo_empty_s;
  assign bit_nxt_s    = bit_q + 6'd1;

  assign SampleReady = (level_q != LevelFull);
  assign Level       = level_q;
  assign Underrun    = underrun_q;
  assign BCLK        = bclk_q;
  assign LRCLK       = lrclk_q;
  assign SDATA       = sdata_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Bit-clock divider, slot sequencing and frame-start loading
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bclk_d        = bclk_q;
    bit_d         = bit_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    left_d        = left_q;
    right_d       = right_q;
    underrun_d    = 1'b0;
    frame_start_s = 1'b0;
    case (state_q)
      StIdle: begin
        div_d   = {DW{1'b0}};
        bclk_d  = 1'b0;
        bit_d   = 6'd0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        if (Enable) begin
          state_d       = StRun;
          frame_start_s = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (div_q != DivLast) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d  = {DW{1'b0}};
          bclk_d = ~bclk_q;
          if (!bclk_q) begin
            bit_d = bit_q;
          end else if (bit_q == 6'd63) begin
            // Enable is only honoured here so a frame is never cut short
            bit_d   = 6'd0;
            lrclk_d = 1'b0;
            sdata_d = 1'b0;
            if (Enable) begin
              frame_start_s = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d   = bit_nxt_s;
            lrclk_d = bit_nxt_s[5];
            if (bit_nxt_s <= 6'd24) begin
              {sdata_d, left_d} = {left_q, 1'b0};
            end else if ((bit_nxt_s >= 6'd33) && (bit_nxt_s <= 6'd56)) begin
              {sdata_d, right_d} = {right_q, 1'b0};
            end else begin
              sdata_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (frame_start_s) begin
      if (fifo_empty_s) begin
        left_d     = 24'd0;
        right_d    = 24'd0;
        underrun_d = 1'b1;
      end else begin
        {left_d, right_d} = mem_q[rd_ptr_q];
      end
    end else begin
      underrun_d = 1'b0;
    end
  end

  // Sample storage
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {SampleLeft, SampleRight};
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      state_q    <= StIdle;
      div_q      <= {DW{1'b0}};
      bit_q      <= 6'd0;
      left_q     <= 24'd0;
      right_q    <= 24'd0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      left_q     <= left_d;
      right_q    <= right_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_gb_apu_i2s_out.sv
// Directed self-checking bench for gb_apu_i2s_out: decodes I2S frames on BCLK rising edges
// and compares against hand-computed words, levels and pulse counts.
module tb_gb_apu_i2s_out;

  logic        CLK = 1'b0;
  logic        RST_n, Enable, SampleValid;
  logic [23:0] SampleLeft, SampleRight;
  logic        SampleReady, Underrun, BCLK, LRCLK, SDATA;
  logic [4:0]  Level;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  int next_val = 0;

  gb_apu_i2s_out #(.FifoDepth(16), .BclkHalfPeriod(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .Enable(Enable), .SampleValid(SampleValid),
    .SampleLeft(SampleLeft), .SampleRight(SampleRight), .SampleReady(SampleReady),
    .Level(Level), .Underrun(Underrun), .BCLK(BCLK), .LRCLK(LRCLK), .SDATA(SDATA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [23:0] getw(input logic [63:0] sd, input int base);
    logic [23:0] w;
    for (int k = 0; k < 24; k++) w[23-k] = sd[base+k];
    return w;
  endfunction

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    SampleValid = 1'b1; SampleLeft = l; SampleRight = r;
    @(posedge CLK); #1;
    SampleValid = 1'b0;
  endtask

  task automatic do_reset;
    RST_n = 1'b0; Enable = 1'b0; SampleValid = 1'b0;
    repeat (2) @(posedge CLK);
    #1; RST_n = 1'b1;
  endtask

  // Decode nbits BCLK rising edges; optional Enable drop / one-shot push / streaming mixer
  task automatic decode(input int nbits, input int dis_at, input int push_at,
                        input logic [23:0] pl, input logic [23:0] pr, input bit stream,
                        output logic [63:0] sd, output logic [63:0] lr, output int ur,
                        output int lv15, output int lr_rise, output int first_rise, output bit ok);
    int n;
    logic pb, plr, rdy;
    n = 0; sd = 64'd0; lr = 64'd0; ur = 0; lv15 = 0; lr_rise = -1; first_rise = -1;
    pb = BCLK; plr = LRCLK;
    for (int c = 0; c < 2000 && n < nbits; c++) begin
      rdy = SampleReady;
      if (stream) begin
        SampleValid = 1'b1;
        SampleLeft  = 24'h100000 + 24'(next_val);
        SampleRight = 24'h200000 + 24'(next_val);
      end
      @(posedge CLK); #1;
      if (stream && rdy) next_val++;
      if (!stream) SampleValid = 1'b0;
      if (Underrun) ur++;
      if (Level == 5'd15) lv15++;
      if (LRCLK && !plr) lr_rise = cyc;
      if (BCLK && !pb) begin
        if (n == 0) first_rise = cyc;
        sd[n] = SDATA;
        lr[n] = LRCLK;
        if (n == dis_at) Enable = 1'b0;
        if (n == push_at) begin
          SampleValid = 1'b1; SampleLeft = pl; SampleRight = pr;
        end
        n++;
      end
      pb = BCLK; plr = LRCLK;
    end
    ok = (n == nbits);
  endtask

  task automatic test_reset;
    RST_n = 1'b0; Enable = 1'b0;
    SampleValid = 1'b1; SampleLeft = 24'h111111; SampleRight = 24'h222222;
    @(posedge CLK); #1;
    SampleValid = 1'b0;
    repeat (2) @(posedge CLK);
    #1; RST_n = 1'b1;
    @(posedge CLK); #1;
    vecs++; if (Level !== 5'd0) begin miss++; $display("FAIL reset_level got %0d exp 0", Level); end
    vecs++; if (SampleReady !== 1'b1) begin miss++; $display("FAIL reset_ready got %b exp 1", SampleReady); end
    vecs++; if (BCLK !== 1'b0) begin miss++; $display("FAIL reset_bclk got %b exp 0", BCLK); end
    vecs++; if (LRCLK !== 1'b0) begin miss++; $display("FAIL reset_lrclk got %b exp 0", LRCLK); end
    vecs++; if (SDATA !== 1'b0) begin miss++; $display("FAIL reset_sdata got %b exp 0", SDATA); end
    vecs++; if (Underrun !== 1'b0) begin miss++; $display("FAIL reset_underrun got %b exp 0", Underrun); end
  endtask

  task automatic test_serialise;
    logic [63:0] sd, lr;
    int ur, lv, r1, r2, fr, e0;
    bit ok;
    do_reset;
    push(24'hA5F00F, 24'h123456);
    vecs++; if (Level !== 5'd1) begin miss++; $display("FAIL ser_push_level got %0d exp 1", Level); end
    Enable = 1'b1;
    @(posedge CLK); #1;
    e0 = cyc;
    vecs++; if (Level !== 5'd0) begin miss++; $display("FAIL ser_pop_level got %0d exp 0", Level); end
    vecs++; if (Underrun !== 1'b0) begin miss++; $display("FAIL ser_no_underrun got %b exp 0", Underrun); end
    decode(64, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
    vecs++; if (!ok) begin miss++; $display("FAIL ser_timeout got %0d exp 1", ok); end
    vecs++; if (fr - e0 !== 8) begin miss++; $display("FAIL ser_first_rise got %0d exp 8", fr - e0); end
    vecs++; if (sd[0] !== 1'b0) begin miss++; $display("FAIL ser_bit0 got %b exp 0", sd[0]); end
    vecs++; if (getw(sd, 1) !== 24'hA5F00F) begin miss++; $display("FAIL ser_left got %h exp a5f00f", getw(sd, 1)); end
    vecs++; if (sd[32:25] !== 8'h00) begin miss++; $display("FAIL ser_pad_left got %h exp 00", sd[32:25]); end
    vecs++; if (getw(sd, 33) !== 24'h123456) begin miss++; $display("FAIL ser_right got %h exp 123456", getw(sd, 33)); end
    vecs++; if (sd[63:57] !== 7'h00) begin miss++; $display("FAIL ser_pad_right got %h exp 00", sd[63:57]); end
    vecs++; if (lr !== 64'hFFFFFFFF_00000000) begin miss++; $display("FAIL ser_lrclk got %h exp ffffffff00000000", lr); end
    decode(64, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r2, fr, ok);
    vecs++; if (r2 - r1 !== 1024) begin miss++; $display("FAIL ser_lr_period got %0d exp 1024", r2 - r1); end
    vecs++; if (ur !== 1) begin miss++; $display("FAIL ser_underrun2 got %0d exp 1", ur); end
    vecs++; if (sd !== 64'd0) begin miss++; $display("FAIL ser_mute2 got %h exp 0", sd); end
  endtask

  task automatic test_fill;
    logic [63:0] sd, lr;
    int ur, lv, r1, fr;
    bit ok;
    do_reset;
    for (int i = 0; i < 16; i++) push(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    vecs++; if (Level !== 5'd16) begin miss++; $display("FAIL fill_level got %0d exp 16", Level); end
    vecs++; if (SampleReady !== 1'b0) begin miss++; $display("FAIL fill_ready got %b exp 0", SampleReady); end
    SampleValid = 1'b1; SampleLeft = 24'h1000AA; SampleRight = 24'h2000AA;
    repeat (4) @(posedge CLK);
    #1;
    vecs++; if (Level !== 5'd16) begin miss++; $display("FAIL fill_held_level got %0d exp 16", Level); end
    SampleValid = 1'b0;
    Enable = 1'b1;
    for (int f = 0; f < 16; f++) begin
      decode(64, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
      vecs++; if (getw(sd, 1) !== 24'h100000 + 24'(f)) begin miss++; $display("FAIL fill_left[%0d] got %h exp %h", f, getw(sd, 1), 24'h100000 + 24'(f)); end
      vecs++; if (getw(sd, 33) !== 24'h200000 + 24'(f)) begin miss++; $display("FAIL fill_right[%0d] got %h exp %h", f, getw(sd, 33), 24'h200000 + 24'(f)); end
      vecs++; if (ur !== 0) begin miss++; $display("FAIL fill_underrun[%0d] got %0d exp 0", f, ur); end
    end
    vecs++; if (Level !== 5'd0) begin miss++; $display("FAIL fill_drained got %0d exp 0", Level); end
  endtask

  task automatic test_underrun;
    logic [63:0] sd, lr;
    int ur, lv, r1, fr;
    bit ok;
    do_reset;
    Enable = 1'b1;
    decode(64, -1, 20, 24'h7FFFFF, 24'h800000, 1'b0, sd, lr, ur, lv, r1, fr, ok);
    vecs++; if (ur !== 1) begin miss++; $display("FAIL ur_pulse1 got %0d exp 1", ur); end
    vecs++; if (sd !== 64'd0) begin miss++; $display("FAIL ur_mute1 got %h exp 0", sd); end
    vecs++; if (Level !== 5'd1) begin miss++; $display("FAIL ur_midpush_level got %0d exp 1", Level); end
    decode(64, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
    vecs++; if (ur !== 0) begin miss++; $display("FAIL ur_pulse2 got %0d exp 0", ur); end
    vecs++; if (getw(sd, 1) !== 24'h7FFFFF) begin miss++; $display("FAIL ur_left2 got %h exp 7fffff", getw(sd, 1)); end
    vecs++; if (getw(sd, 33) !== 24'h800000) begin miss++; $display("FAIL ur_right2 got %h exp 800000", getw(sd, 33)); end
    decode(64, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
    vecs++; if (ur !== 1) begin miss++; $display("FAIL ur_pulse3 got %0d exp 1", ur); end
    vecs++; if (sd !== 64'd0) begin miss++; $display("FAIL ur_mute3 got %h exp 0", sd); end
  endtask

  task automatic test_push_pop_full;
    logic [63:0] sd, lr;
    int ur, lv, r1, fr;
    bit ok;
    logic rdy;
    do_reset;
    next_val = 0;
    for (int c = 0; c < 24; c++) begin
      SampleValid = 1'b1;
      SampleLeft  = 24'h100000 + 24'(next_val);
      SampleRight = 24'h200000 + 24'(next_val);
      rdy = SampleReady;
      @(posedge CLK); #1;
      if (rdy) next_val++;
    end
    vecs++; if (next_val !== 16) begin miss++; $display("FAIL full_accepts got %0d exp 16", next_val); end
    vecs++; if (Level !== 5'd16) begin miss++; $display("FAIL full_level got %0d exp 16", Level); end
    Enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      decode(64, -1, -1, 24'd0, 24'd0, 1'b1, sd, lr, ur, lv, r1, fr, ok);
      vecs++; if (getw(sd, 1) !== 24'h100000 + 24'(f)) begin miss++; $display("FAIL full_left[%0d] got %h exp %h", f, getw(sd, 1), 24'h100000 + 24'(f)); end
      vecs++; if (getw(sd, 33) !== 24'h200000 + 24'(f)) begin miss++; $display("FAIL full_right[%0d] got %h exp %h", f, getw(sd, 33), 24'h200000 + 24'(f)); end
      vecs++; if (lv !== 1) begin miss++; $display("FAIL full_lvl15_cycles[%0d] got %0d exp 1", f, lv); end
    end
    vecs++; if (next_val !== 20) begin miss++; $display("FAIL full_total_accepts got %0d exp 20", next_val); end
    vecs++; if (Level !== 5'd16) begin miss++; $display("FAIL full_level_after got %0d exp 16", Level); end
    SampleValid = 1'b0;
    for (int f = 4; f < 6; f++) begin
      decode(64, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
      vecs++; if (getw(sd, 1) !== 24'h100000 + 24'(f)) begin miss++; $display("FAIL full_drain_left[%0d] got %h exp %h", f, getw(sd, 1), 24'h100000 + 24'(f)); end
      vecs++; if (getw(sd, 33) !== 24'h200000 + 24'(f)) begin miss++; $display("FAIL full_drain_right[%0d] got %h exp %h", f, getw(sd, 33), 24'h200000 + 24'(f)); end
    end
  endtask

  task automatic test_disable_reset;
    logic [63:0] sd, lr;
    int ur, lv, r1, fr, e0, rises;
    bit ok;
    logic pb;
    do_reset;
    push(24'h654321, 24'hFEDCBA);
    Enable = 1'b1;
    decode(64, 10, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
    vecs++; if (!ok) begin miss++; $display("FAIL dis_frame_complete got %0d exp 1", ok); end
    vecs++; if (getw(sd, 1) !== 24'h654321) begin miss++; $display("FAIL dis_left got %h exp 654321", getw(sd, 1)); end
    vecs++; if (getw(sd, 33) !== 24'hFEDCBA) begin miss++; $display("FAIL dis_right got %h exp fedcba", getw(sd, 33)); end
    repeat (30) @(posedge CLK);
    #1;
    vecs++; if ({BCLK, LRCLK, SDATA} !== 3'b000) begin miss++; $display("FAIL dis_idle_outputs got %b exp 000", {BCLK, LRCLK, SDATA}); end
    rises = 0; pb = BCLK;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      if (BCLK && !pb) rises++;
      pb = BCLK;
    end
    vecs++; if (rises !== 0) begin miss++; $display("FAIL dis_idle_bclk got %0d exp 0", rises); end
    Enable = 1'b1;
    decode(41, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
    vecs++; if (lr[40] !== 1'b1) begin miss++; $display("FAIL rst_pre_lrclk got %b exp 1", lr[40]); end
    RST_n = 1'b0; Enable = 1'b0;
    @(posedge CLK); #1;
    vecs++; if ({BCLK, LRCLK, SDATA, Underrun} !== 4'b0000) begin miss++; $display("FAIL rst_mid_outputs got %b exp 0000", {BCLK, LRCLK, SDATA, Underrun}); end
    RST_n = 1'b1;
    push(24'h13579B, 24'h2468AC);
    Enable = 1'b1;
    @(posedge CLK); #1;
    e0 = cyc;
    decode(64, -1, -1, 24'd0, 24'd0, 1'b0, sd, lr, ur, lv, r1, fr, ok);
    vecs++; if (fr - e0 !== 8) begin miss++; $display("FAIL rst_fresh_rise got %0d exp 8", fr - e0); end
    vecs++; if (lr !== 64'hFFFFFFFF_00000000) begin miss++; $display("FAIL rst_fresh_lrclk got %h exp ffffffff00000000", lr); end
    vecs++; if (getw(sd, 1) !== 24'h13579B) begin miss++; $display("FAIL rst_fresh_left got %h exp 13579b", getw(sd, 1)); end
    vecs++; if (getw(sd, 33) !== 24'h2468AC) begin miss++; $display("FAIL rst_fresh_right got %h exp 2468ac", getw(sd, 33)); end
  endtask

  initial begin
    RST_n = 1'b0; Enable = 1'b0; SampleValid = 1'b0;
    SampleLeft = 24'd0; SampleRight = 24'd0;
    test_reset;
    test_serialise;
    test_fill;
    test_underrun;
    test_push_pop_full;
    test_disable_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
